// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide op codes (also decoded by the logic
// controller), mul/div FSM state encodings and the default datapath width.
package cpu_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_negate.sv
// Conditional two's complement; used for operand magnitudes and result sign fix.
module md_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit
// per cycle on operand magnitudes, with sign correction in a final FIX cycle.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH   = MD_WIDTH,
  parameter int CNTBITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  md_state_e          state_q;
  logic [CNTBITS-1:0] cnt_q;
  logic               is_div_q, neg_res_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0]   dvs_q, rs_raw_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Operand decode at the sampling edge.
  logic             op_signed, op_div, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;

  assign op_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
  assign op_div    = (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  assign rs_neg    = op_signed & rs_data[WIDTH-1];
  assign rt_neg    = op_signed & rt_data[WIDTH-1];

  md_negate #(.W(WIDTH)) u_abs_rs (.val_i(rs_data), .neg_i(rs_neg), .res_o(rs_abs));
  md_negate #(.W(WIDTH)) u_abs_rt (.val_i(rt_data), .neg_i(rt_neg), .res_o(rt_abs));

  // One iteration. acc_q holds {hi_part, lo_part}: product/multiplier for
  // multiply, remainder/quotient-dividend for divide. The shifted remainder
  // needs WIDTH+1 bits; after a restoring step it always fits in WIDTH again.
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_sub, rem_nxt;
  logic               rem_ge;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, dvs_q};
    rem_sub  = rem_sh[WIDTH-1:0] - dvs_q;
    rem_nxt  = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
    if (is_div_q) acc_step = {rem_nxt, acc_q[WIDTH-2:0], rem_ge};
    else          acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Sign correction of the magnitude results.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  md_negate #(.W(2*WIDTH)) u_fix_prod (.val_i(acc_q), .neg_i(neg_res_q), .res_o(prod_fix));
  md_negate #(.W(WIDTH)) u_fix_quo (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .res_o(quo_fix));
  md_negate #(.W(WIDTH)) u_fix_rem (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .res_o(rem_fix));

  logic [WIDTH-1:0] hi_d, lo_d;

  always_comb begin
    hi_d = prod_fix[2*WIDTH-1:WIDTH];
    lo_d = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        hi_d = rs_raw_q;
        lo_d = '1;
      end else begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      dvs_q     <= '0;
      rs_raw_q  <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            is_div_q  <= op_div;
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= rs_neg;
            dz_q      <= (rt_data == '0);
            rs_raw_q  <= rs_data;
            dvs_q     <= op_div ? rt_abs : rs_abs;
            acc_q     <= {{WIDTH{1'b0}}, (op_div ? rs_abs : rt_abs)};
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= MD_CALC;
          end
        end
        MD_CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNTBITS'(WIDTH-1)) state_q <= MD_FIX;
        end
        MD_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          dbz_q   <= is_div_q & dz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed plan vectors plus randomized
// operations against a 64-bit arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .CNTBITS(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  // Reference model: plain 64-bit arithmetic (C-style truncating division).
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    ed = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin sa = $signed(a); sb = $signed(b); p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF; eh = a; ed = 1'b1;
        end else if (o == 2'b10) begin
          sa = $signed(a); sb = $signed(b); sq = sa / sb; sr = sa % sb;
          el = sq[31:0]; eh = sr[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endtask

  // Issue one op and wait for done (bounded). Reports latency, whether busy was
  // high throughout, whether hi/lo held until done and the flag right after start.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok, output logic hold_ok,
                        output logic dbz_start);
    logic [31:0] h0, l0;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
    lat = 0; busy_ok = busy; hold_ok = 1'b1; dbz_start = div_by_zero;
    h0 = hi; l0 = lo;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
      if (!done && (hi !== h0 || lo !== l0)) hold_ok = 1'b0;
    end
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] t_a  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100};
    logic [31:0] t_b  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd7};
    logic [31:0] t_hi [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] t_lo [4] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'hFFFF_FFFD, 32'd14};
    int lat; logic bok, hok, dz0;
    for (int i = 0; i < 4; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat, bok, hok, dz0);
      n_cmp++; if (lat != 33) begin n_err++; $display("FAIL dir%0d_latency: got %0d expected 33", i, lat); end
      n_cmp++; if (!bok) begin n_err++; $display("FAIL dir%0d_busy: got dropped expected held", i); end
      n_cmp++; if (hi !== t_hi[i]) begin n_err++; $display("FAIL dir%0d_hi: got %h expected %h", i, hi, t_hi[i]); end
      n_cmp++; if (lo !== t_lo[i]) begin n_err++; $display("FAIL dir%0d_lo: got %h expected %h", i, lo, t_lo[i]); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dir%0d_dbz: got %b expected 0", i, div_by_zero); end
    end
  endtask

  task automatic test_div_by_zero();
    int lat; logic bok, hok, dz0;
    run_op(2'b11, 32'd100, 32'd0, lat, bok, hok, dz0);
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL dbz_latency: got %0d expected 33", lat); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dbz_lo: got %h expected ffffffff", lo); end
    n_cmp++; if (hi !== 32'd100) begin n_err++; $display("FAIL dbz_hi: got %h expected 00000064", hi); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
    run_op(2'b00, 32'd2, 32'd3, lat, bok, hok, dz0);
    n_cmp++; if (dz0 !== 1'b0) begin n_err++; $display("FAIL dbz_clear_at_start: got %b expected 0", dz0); end
    n_cmp++; if (!hok) begin n_err++; $display("FAIL dbz_hold: hi/lo changed mid-op expected stable"); end
    n_cmp++; if ({hi, lo} !== 64'd6) begin n_err++; $display("FAIL dbz_next_mult: got %h expected 6", {hi, lo}); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dbz_next_flag: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_ignore_start();
    logic [31:0] a, b, eh, el;
    logic ed;
    int lat;
    a = $urandom; b = $urandom;
    model(2'b00, a, b, eh, el, ed);
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = a; rt_data = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    repeat (9) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_data = ~a; rt_data = 32'd5;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
    n_cmp++; if ({hi, lo} !== {eh, el}) begin n_err++; $display("FAIL ignore_result: got %h expected %h", {hi, lo}, {eh, el}); end
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL ignore_no_queue: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_async_reset();
    int lat; logic bok, hok, dz0;
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs_data = 32'd1000; rt_data = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL areset_done: got %b expected 0", done); end
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL areset_hilo: got %h expected 0", {hi, lo}); end
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok, hok, dz0);
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL ovf_latency: got %0d expected 33", lat); end
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL ovf_hi: got %h expected 0", hi); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL ovf_flag: got %b expected 0", div_by_zero); end
  endtask

  // Consecutive run_op calls issue start in the done cycle, so each op must
  // still complete with full latency (a dropped start would time out).
  task automatic test_back_to_back(input int n, input string tag);
    logic [1:0] o; logic [31:0] a, b, eh, el; logic ed;
    int lat; logic bok, hok, dz0;
    for (int i = 0; i < n; i++) begin
      o = 2'($urandom); a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'h8000_0000;
        3: b = 32'h8000_0000;
        4: b = $urandom_range(1, 20);
        default: ;
      endcase
      model(o, a, b, eh, el, ed);
      run_op(o, a, b, lat, bok, hok, dz0);
      n_cmp++; if (lat != 33) begin n_err++; $display("FAIL %s%0d_latency: got %0d expected 33", tag, i, lat); end
      n_cmp++; if (!bok || !hok) begin n_err++; $display("FAIL %s%0d_busy_hold: got busy_ok=%b hold_ok=%b expected 1 1", tag, i, bok, hok); end
      n_cmp++; if ({hi, lo, div_by_zero} !== {eh, el, ed}) begin
        n_err++;
        $display("FAIL %s%0d_result: op=%0d a=%h b=%h got %h_%h_%b expected %h_%h_%b",
                 tag, i, o, a, b, hi, lo, div_by_zero, eh, el, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_ignore_start();
    test_async_reset();
    test_back_to_back(6, "b2b");
    test_back_to_back(24, "rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
